// File: rtl/multdiv_iter.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring) unit.
// Fixed WIDTH+1 cycle latency; results, exception and ready pulse are registered.
module multdiv_iter #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   input  logic             ctrl_MULT,
   input  logic             ctrl_DIV,
   input  logic             ctrl_flush,
   output logic [WIDTH-1:0] data_result,
   output logic             data_exception,
   output logic             data_resultRDY,
   output logic             busy
);

   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL,
      S_DIV,
      S_DONE
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH:0]     acc_q, acc_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               bit_q, bit_d;
   logic [WIDTH-1:0]   m_q, m_d;
   logic               neg_q, neg_d;
   logic               dz_q, dz_d;
   logic               dovf_q, dovf_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic               exc_q, exc_d;
   logic               rdy_q, rdy_d;
   logic               busy_q, busy_d;

   logic               start;
   logic [WIDTH:0]     m_ext;
   logic [WIDTH:0]     booth_sum;
   logic [WIDTH:0]     rem_sh;
   logic [WIDTH:0]     rem_sub;
   logic               rem_ge;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic [WIDTH-1:0]   quot_neg;
   logic [WIDTH:0]     prod_hi;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         lo_q     <= '0;
         bit_q    <= 1'b0;
         m_q      <= '0;
         neg_q    <= 1'b0;
         dz_q     <= 1'b0;
         dovf_q   <= 1'b0;
         result_q <= '0;
         exc_q    <= 1'b0;
         rdy_q    <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         lo_q     <= lo_d;
         bit_q    <= bit_d;
         m_q      <= m_d;
         neg_q    <= neg_d;
         dz_q     <= dz_d;
         dovf_q   <= dovf_d;
         result_q <= result_d;
         exc_q    <= exc_d;
         rdy_q    <= rdy_d;
         busy_q   <= busy_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      lo_d     = lo_q;
      bit_d    = bit_q;
      m_d      = m_q;
      neg_d    = neg_q;
      dz_d     = dz_q;
      dovf_d   = dovf_q;
      result_d = result_q;
      exc_d    = exc_q;
      rdy_d    = 1'b0;
      busy_d   = 1'b0;

      start     = ctrl_MULT ^ ctrl_DIV;
      m_ext     = {m_q[WIDTH-1], m_q};
      booth_sum = acc_q;
      case ({lo_q[0], bit_q})
         2'b01:   booth_sum = acc_q + m_ext;
         2'b10:   booth_sum = acc_q - m_ext;
         default: booth_sum = acc_q;
      endcase
      // Restoring divide: shift next dividend bit into the partial remainder.
      rem_sh   = {acc_q[WIDTH-1:0], lo_q[WIDTH-1]};
      rem_ge   = (rem_sh >= {1'b0, m_q});
      rem_sub  = rem_sh - {1'b0, m_q};
      a_mag    = data_operandA[WIDTH-1] ? (~data_operandA + WIDTH'(1)) : data_operandA;
      b_mag    = data_operandB[WIDTH-1] ? (~data_operandB + WIDTH'(1)) : data_operandB;
      quot_neg = ~lo_q + WIDTH'(1);
      prod_hi  = {acc_q[WIDTH-1:0], lo_q[WIDTH-1]};

      if (start) begin
         cnt_d  = '0;
         acc_d  = '0;
         bit_d  = 1'b0;
         neg_d  = 1'b0;
         dz_d   = 1'b0;
         dovf_d = 1'b0;
         if (ctrl_MULT) begin
            state_d = S_MUL;
            lo_d    = data_operandB;
            m_d     = data_operandA;
         end else begin
            state_d = S_DIV;
            lo_d    = a_mag;
            m_d     = b_mag;
            neg_d   = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            dz_d    = (data_operandB == '0);
            dovf_d  = (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) && (&data_operandB);
         end
      end else if (ctrl_flush) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_MUL: begin
               if (cnt_q == CNT_W'(WIDTH)) begin
                  state_d  = S_DONE;
                  result_d = lo_q;
                  exc_d    = !((&prod_hi) || (~|prod_hi));
               end else begin
                  acc_d = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
                  lo_d  = {booth_sum[0], lo_q[WIDTH-1:1]};
                  bit_d = lo_q[0];
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            S_DIV: begin
               if (cnt_q == CNT_W'(WIDTH)) begin
                  state_d  = S_DONE;
                  result_d = dz_q ? '0 : (neg_q ? quot_neg : lo_q);
                  exc_d    = dz_q | dovf_q;
               end else begin
                  acc_d = rem_ge ? rem_sub : rem_sh;
                  lo_d  = {lo_q[WIDTH-2:0], rem_ge};
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end

      busy_d = (state_d == S_MUL) || (state_d == S_DIV);
      rdy_d  = (state_d == S_DONE);
   end

   assign data_result    = result_q;
   assign data_exception = exc_q;
   assign data_resultRDY = rdy_q;
   assign busy           = busy_q;

endmodule
